da_dct_row_seq: RTL and testbench
=================================

Name: da_dct_row_seq

Overview:
- Bit-serial distributed-arithmetic sequencer for one DCT output row.
- Accepts four signed butterfly terms x0..x3 and walks their bits LSB-first.
- Each cycle it drives the 8-entry, 16-bit coefficient ROM's 3-bit address and chip select, then conditionally negates the returned word.
- Shift-accumulates the terms into one signed row coefficient and presents it on a valid/ready output. One instance per ROM (z1..z7).

Parameters:
DATA_W, 8, bits per input term (two's complement); also the number of RUN cycles.
COEF_W, 16, ROM word width (signed fixed point).
ACC_W, COEF_W+DATA_W+1, derived (localparam, not overridable); accumulator/output width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  x0..x3 valid
in_ready  out  1  sequencer can accept a new set
x0  in  DATA_W  term selecting add/subtract of the ROM word
x1  in  DATA_W  ROM address bit 2 source
x2  in  DATA_W  ROM address bit 1 source
x3  in  DATA_W  ROM address bit 0 source
rom_addr  out  3  ROM address
rom_cs  out  1  ROM chip select (ROM outputs 0 when low)
rom_data  in  COEF_W  combinational ROM word, signed
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
out_data  out  ACC_W  signed row result
busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE, bit counter=0, acc=0, captured terms=0, in_ready=1, out_valid=0, out_data=0, rom_cs=0, rom_addr=0, busy=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a clock edge: capture x0..x3, acc<=0, cnt<=0, go to RUN.
  - in_valid while not in IDLE is ignored (no capture, no error).
- RUN:
  - in_ready=0, rom_cs=1.
  - rom_addr={x1[cnt],x2[cnt],x3[cnt]} from captured regs.
  - Term t = x0[cnt] ? -sext(rom_data) : sext(rom_data), evaluated at ACC_W bits.
  - acc <= acc + (t <<< cnt).
  - cnt increments each cycle. On the edge where cnt==DATA_W-1: cnt<=0, out_data<=final acc, go to DONE.
  - Exactly DATA_W RUN cycles.
- DONE:
  - out_valid=1, rom_cs=0, rom_addr=0.
  - out_data holds stable until out_ready sampled high; then out_valid<=0 and go to IDLE.
  - out_ready=1 in the same cycle out_valid rises completes the transfer in that cycle.
  - No new input is accepted in DONE; the block is single-buffered.
- rom_cs=0 and rom_addr=0 in IDLE and DONE, so the ROM reads 0 there.
- Latency: accept edge at cycle k; RUN cycles k+1..k+DATA_W; out_valid high from cycle k+DATA_W+1.
- Throughput: with out_ready tied high, one result every DATA_W+2 cycles.
- Arithmetic:
  - Result = sum over b=0..DATA_W-1 of 2^b * t_b.
  - All internal math is signed at ACC_W bits; no saturation is needed because ACC_W covers the worst case.
  - The negate of -32768 is representable at ACC_W bits.
- Reset asserted mid-RUN or mid-DONE: outputs take reset values immediately; the partial result is discarded; no out_valid pulse.
- busy = (state!=IDLE).

Test Plan:
- Reset then idle: rst_n low 3 cycles, release -> in_ready=1, out_valid=0, rom_cs=0, rom_addr=0, out_data=0. Assert rst_n asynchronously mid-cycle -> outputs clear before the next edge.
- ROM model (0:0xE333, 1:0xADFC, 2:0xEFAF, 3:0xBA78, 4:0x21F8, 5:0xECC1, 6:0x2E74, 7:0xF93E), x0..x3 all 0 -> rom_addr=0 for 8 cycles, out_data = 255 * -7373 = -1880115, out_valid exactly 9 cycles after the accept edge.
- x0=0xFF, others 0 -> every term negated, out_data=+1880115.
- x1=0x01, others 0 -> rom_addr=4 in RUN cycle 0 then 0, out_data = 8696 + 254*(-7373) = -1864046.
- Backpressure: out_ready low 5 cycles after out_valid -> out_data stable, in_ready=0, in_valid pulses ignored. out_ready high -> next cycle IDLE, a new set is accepted. Back-to-back with out_ready=1 -> results every 10 cycles.
- Reset at RUN cycle 4 -> no out_valid. A following all-zero input gives -1880115, proving acc and cnt were cleared.

Source files
------------

// File: rtl/da_dct_row_seq.sv
// Bit-serial distributed-arithmetic sequencer for one DCT output row.
// Walks four captured terms LSB-first, reads the coefficient ROM, and shift-accumulates.
module da_dct_row_seq #(
    parameter  int DATA_W = 8,
    parameter  int COEF_W = 16,
    localparam int ACC_W  = COEF_W + DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    output logic [2:0]        rom_addr,
    output logic              rom_cs,
    input  logic [COEF_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              busy
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]              state;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_W-1:0]       x0_q, x1_q, x2_q, x3_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] rom_ext, term, acc_nxt;

    assign in_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);

    // ROM is only selected in RUN, so its word reads as zero in IDLE and DONE.
    always_comb begin
        rom_cs   = (state == S_RUN);
        rom_addr = rom_cs ? {x1_q[cnt], x2_q[cnt], x3_q[cnt]} : 3'd0;
        rom_ext  = {{(ACC_W-COEF_W){rom_data[COEF_W-1]}}, rom_data};
        term     = x0_q[cnt] ? -rom_ext : rom_ext;
        acc_nxt  = acc + (term <<< cnt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            x3_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    x0_q  <= x0;
                    x1_q  <= x1;
                    x2_q  <= x2;
                    x3_q  <= x3;
                    acc   <= '0;
                    cnt   <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    acc <= acc_nxt;
                    if (cnt == CNT_LAST) begin
                        cnt       <= '0;
                        out_data  <= acc_nxt;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_da_dct_row_seq.sv
// Directed bench for da_dct_row_seq with a combinational coefficient ROM model.
module tb_da_dct_row_seq;
    localparam int DATA_W = 8;
    localparam int COEF_W = 16;
    localparam int ACC_W  = COEF_W + DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic [2:0]        rom_addr;
    logic              rom_cs;
    logic [COEF_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [ACC_W-1:0]  out_data;
    logic              busy;

    int n_chk = 0;
    int n_pass = 0;

    da_dct_row_seq #(.DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        rom_data = 16'h0000;
        if (rom_cs) begin
            case (rom_addr)
                3'd0: rom_data = 16'hE333;
                3'd1: rom_data = 16'hADFC;
                3'd2: rom_data = 16'hEFAF;
                3'd3: rom_data = 16'hBA78;
                3'd4: rom_data = 16'h21F8;
                3'd5: rom_data = 16'hECC1;
                3'd6: rom_data = 16'h2E74;
                default: rom_data = 16'hF93E;
            endcase
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic longint sdata();
        return longint'($signed(out_data));
    endfunction

    // Accept one set, check every RUN-cycle address, land in DONE and check the result.
    task automatic run_set(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [7:0] a3, input longint exp, input string tag);
        logic [2:0] ea;
        x0 = a0; x1 = a1; x2 = a2; x3 = a3;
        in_valid = 1'b1;
        chk({tag, " in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, " busy"}, busy, 1);
        chk({tag, " cs"}, rom_cs, 1);
        for (int i = 0; i < DATA_W; i++) begin
            ea = {a1[i], a2[i], a3[i]};
            chk($sformatf("%s addr%0d", tag, i), rom_addr, ea);
            chk($sformatf("%s nv%0d", tag, i), out_valid, 0);
            tick();
        end
        chk({tag, " valid"}, out_valid, 1);
        chk({tag, " data"}, sdata(), exp);
        chk({tag, " done_cs"}, rom_cs, 0);
    endtask

    initial begin
        int n;
        // reset
        repeat (3) tick();
        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();
        chk("idle in_ready", in_ready, 1);
        chk("idle out_valid", out_valid, 0);
        chk("idle cs", rom_cs, 0);
        chk("idle addr", rom_addr, 0);
        chk("idle data", sdata(), 0);
        chk("idle busy", busy, 0);

        // directed vectors
        run_set(8'h00, 8'h00, 8'h00, 8'h00, -1880115, "zero");
        tick();
        chk("zero release", in_ready, 1);
        run_set(8'hFF, 8'h00, 8'h00, 8'h00, 1880115, "neg");
        tick();
        run_set(8'h00, 8'h01, 8'h00, 8'h00, -1864046, "x1b0");
        tick();
        run_set(8'h00, 8'h00, 8'h00, 8'h80, -3623859, "x3b7");
        tick();
        run_set(8'h80, 8'hFF, 8'hFF, 8'hFF, 1730, "msbneg");
        tick();

        // backpressure: result held, new inputs ignored
        out_ready = 1'b0;
        run_set(8'h00, 8'h00, 8'h00, 8'h00, -1880115, "bp");
        x0 = 8'hFF; x1 = 8'h55;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            tick();
            chk($sformatf("bp hold%0d", i), sdata(), -1880115);
            chk($sformatf("bp valid%0d", i), out_valid, 1);
            chk($sformatf("bp in_ready%0d", i), in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp release valid", out_valid, 0);
        chk("bp release idle", in_ready, 1);
        run_set(8'h00, 8'h01, 8'h00, 8'h00, -1864046, "after_bp");
        tick();

        // back-to-back throughput
        x0 = '0; x1 = '0; x2 = '0; x3 = '0;
        in_valid = 1'b1;
        n = 0;
        while (!out_valid && n < 30) begin tick(); n++; end
        chk("b2b first", out_valid, 1);
        n = 0;
        do begin tick(); n++; end while (!out_valid && n < 30);
        chk("b2b period", n, 10);
        chk("b2b data", sdata(), -1880115);
        in_valid = 1'b0;
        tick();

        // asynchronous reset in the middle of RUN
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid rst busy", busy, 0);
        chk("mid rst cs", rom_cs, 0);
        chk("mid rst data", sdata(), 0);
        chk("mid rst in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("mid rst no valid", n, 0);
        run_set(8'h00, 8'h00, 8'h00, 8'h00, -1880115, "post_rst");
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
